// File: rtl/xgriscv_dmem_resp_pkg.sv
// Shared encodings and payload types for the handshaked data-memory responder.
package xgriscv_dmem_resp_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  funct3;
        logic [31:0] wdata;
    } req_t;

    // Encodings with no meaning for the given direction.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic ill;
        ill = 1'b1;
        if (we) begin
            if (f3 == F3_SB || f3 == F3_SH || f3 == F3_SW) ill = 1'b0;
        end else begin
            if (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW ||
                f3 == F3_LBU || f3 == F3_LHU) ill = 1'b0;
        end
        return ill;
    endfunction

endpackage

// File: rtl/xgriscv_dmem_resp_if.sv
// Request/response channel pair between the memory stage and the responder.
interface xgriscv_dmem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/xgriscv_mem_align.sv
// RV32I sub-word lane logic: byte enables, store lane replication, load extension.
module xgriscv_mem_align
    import xgriscv_dmem_resp_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rext,
    output logic        misalign
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        case (addr_lo)
            2'd0:    sel_byte = rword[7:0];
            2'd1:    sel_byte = rword[15:8];
            2'd2:    sel_byte = rword[23:16];
            default: sel_byte = rword[31:24];
        endcase
        sel_half = addr_lo[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        be       = 4'b0000;
        wword    = 32'd0;
        rext     = 32'd0;
        misalign = 1'b0;
        case (funct3)
            F3_LB, F3_LBU: begin
                be    = 4'(4'b0001 << addr_lo);
                wword = {4{wdata[7:0]}};
                rext  = (funct3 == F3_LB) ? {{24{sel_byte[7]}}, sel_byte}
                                          : {24'd0, sel_byte};
            end
            F3_LH, F3_LHU: begin
                misalign = addr_lo[0];
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword    = {2{wdata[15:0]}};
                rext     = (funct3 == F3_LH) ? {{16{sel_half[15]}}, sel_half}
                                             : {16'd0, sel_half};
            end
            F3_LW: begin
                misalign = (addr_lo != 2'd0);
                be       = 4'b1111;
                wword    = wdata;
                rext     = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/xgriscv_dmem_resp.sv
// Data-memory responder: one outstanding request, programmable latency, registered response.
module xgriscv_dmem_resp
    import xgriscv_dmem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input logic             clk,
    input logic             reset,
    xgriscv_dmem_resp_if.slave bus
);

    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W  = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam bit          DIRECT = (LATENCY == 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    req_t               lat;
    logic               resp_valid_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_err_q;

    logic [31:0]        mem [DEPTH_WORDS];

    req_t               live;
    req_t               acc;
    logic               do_access;
    logic [AW-1:0]      widx;
    logic [31:0]        rword;
    logic [3:0]         be;
    logic [31:0]        wword;
    logic [31:0]        rext;
    logic               misalign;
    logic               range_err;
    logic               acc_err;
    logic [31:0]        acc_rdata;
    logic               mem_we;

    assign live = '{we: bus.req_we, addr: bus.req_addr,
                    funct3: bus.req_funct3, wdata: bus.req_wdata};

    // With LATENCY=1 the access happens at the acceptance edge, so it uses the live request.
    assign acc       = (state == S_IDLE) ? live : lat;
    assign do_access = ((state == S_IDLE) && bus.req_valid && DIRECT) ||
                       ((state == S_WAIT) && (cnt == '0));

    assign widx      = acc.addr[AW+1:2];
    assign rword     = mem[widx];
    assign range_err = (acc.addr[31:AW+2] != '0);

    xgriscv_mem_align u_align (
        .funct3   (acc.funct3),
        .addr_lo  (acc.addr[1:0]),
        .wdata    (acc.wdata),
        .rword    (rword),
        .be       (be),
        .wword    (wword),
        .rext     (rext),
        .misalign (misalign)
    );

    assign acc_err   = range_err | misalign | f3_illegal(acc.we, acc.funct3);
    assign acc_rdata = (acc_err || acc.we) ? 32'd0 : rext;
    assign mem_we    = do_access && acc.we && !acc_err && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            lat          <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        lat <= live;
                        if (DIRECT) begin
                            state        <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= acc_rdata;
                            resp_err_q   <= acc_err;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_W'(LATENCY - 2);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state        <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= acc_rdata;
                        resp_err_q   <= acc_err;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        state        <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= 32'd0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset; unselected lanes keep their contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_xgriscv_dmem_resp.sv
// Directed bench for xgriscv_dmem_resp with LATENCY 1, 3 and 4 instances on one clock.
module tb_xgriscv_dmem_resp;

    logic        clk;
    logic        rst1, rst3, rst4;
    int          sel;
    logic        req_valid, req_we, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        r_ready, r_valid, r_err;
    logic [31:0] r_rdata;
    int          checks;
    int          failures;

    xgriscv_dmem_resp_if if1 ();
    xgriscv_dmem_resp_if if3 ();
    xgriscv_dmem_resp_if if4 ();

    assign if1.req_valid  = req_valid && (sel == 1);
    assign if1.resp_ready = resp_ready && (sel == 1);
    assign if1.req_we = req_we; assign if1.req_addr = req_addr;
    assign if1.req_funct3 = req_funct3; assign if1.req_wdata = req_wdata;
    assign if3.req_valid  = req_valid && (sel == 3);
    assign if3.resp_ready = resp_ready && (sel == 3);
    assign if3.req_we = req_we; assign if3.req_addr = req_addr;
    assign if3.req_funct3 = req_funct3; assign if3.req_wdata = req_wdata;
    assign if4.req_valid  = req_valid && (sel == 4);
    assign if4.resp_ready = resp_ready && (sel == 4);
    assign if4.req_we = req_we; assign if4.req_addr = req_addr;
    assign if4.req_funct3 = req_funct3; assign if4.req_wdata = req_wdata;

    assign r_ready = (sel == 3) ? if3.req_ready  : (sel == 4) ? if4.req_ready  : if1.req_ready;
    assign r_valid = (sel == 3) ? if3.resp_valid : (sel == 4) ? if4.resp_valid : if1.resp_valid;
    assign r_rdata = (sel == 3) ? if3.resp_rdata : (sel == 4) ? if4.resp_rdata : if1.resp_rdata;
    assign r_err   = (sel == 3) ? if3.resp_err   : (sel == 4) ? if4.resp_err   : if1.resp_err;

    xgriscv_dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(1)) d1 (.clk(clk), .reset(rst1), .bus(if1));
    xgriscv_dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(3)) d3 (.clk(clk), .reset(rst3), .bus(if3));
    xgriscv_dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(4)) d4 (.clk(clk), .reset(rst4), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction with resp_ready raised right after acceptance.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd, input int lat,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int k;
        k = 0;
        while (!r_ready && k < 20) begin tick(); k++; end
        check({tag, "_ready"}, 32'(r_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
        tick();
        req_valid = 1'b0;
        resp_ready = 1'b1;
        k = 0;
        while (!r_valid && k < 20) begin tick(); k++; end
        check({tag, "_lat"}, 32'(k), 32'(lat - 1));
        check({tag, "_rdata"}, r_rdata, exp_rdata);
        check({tag, "_err"}, 32'(r_err), 32'(exp_err));
        tick();
        check({tag, "_done"}, 32'(r_valid), 32'd0);
        resp_ready = 1'b0;
    endtask

    initial begin
        int k;
        checks = 0; failures = 0;
        sel = 1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_funct3 = 3'd0;
        req_wdata = 32'd0; resp_ready = 1'b0;
        rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
        tick(); tick();
        rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
        tick();
        check("rst_req_ready", 32'(r_ready), 32'd1);
        check("rst_resp_valid", 32'(r_valid), 32'd0);
        check("rst_resp_rdata", r_rdata, 32'd0);
        check("rst_resp_err", 32'(r_err), 32'd0);

        // LATENCY=1 store/load
        do_req("sw10", 1'b1, 32'h10, 3'b010, 32'h8000_00F1, 1, 32'd0, 1'b0);
        do_req("lw10", 1'b0, 32'h10, 3'b010, 32'd0, 1, 32'h8000_00F1, 1'b0);

        // Sub-word lanes
        do_req("sw20", 1'b1, 32'h20, 3'b010, 32'd0, 1, 32'd0, 1'b0);
        do_req("sb21", 1'b1, 32'h21, 3'b000, 32'hFFFF_FFAB, 1, 32'd0, 1'b0);
        do_req("sh22", 1'b1, 32'h22, 3'b001, 32'hFFFF_1234, 1, 32'd0, 1'b0);
        do_req("lw20", 1'b0, 32'h20, 3'b010, 32'd0, 1, 32'h1234_AB00, 1'b0);
        do_req("lb21", 1'b0, 32'h21, 3'b000, 32'd0, 1, 32'hFFFF_FFAB, 1'b0);
        do_req("lbu21", 1'b0, 32'h21, 3'b100, 32'd0, 1, 32'h0000_00AB, 1'b0);
        do_req("lh22", 1'b0, 32'h22, 3'b001, 32'd0, 1, 32'h0000_1234, 1'b0);
        do_req("lh20", 1'b0, 32'h20, 3'b001, 32'd0, 1, 32'hFFFF_AB00, 1'b0);
        do_req("lhu20", 1'b0, 32'h20, 3'b101, 32'd0, 1, 32'h0000_AB00, 1'b0);
        do_req("lb23", 1'b0, 32'h23, 3'b000, 32'd0, 1, 32'h0000_0012, 1'b0);

        // Errors and range boundary
        do_req("lw13", 1'b0, 32'h13, 3'b010, 32'd0, 1, 32'd0, 1'b1);
        do_req("sh11", 1'b1, 32'h11, 3'b001, 32'h5555, 1, 32'd0, 1'b1);
        do_req("sbu10", 1'b1, 32'h10, 3'b100, 32'h77, 1, 32'd0, 1'b1);
        do_req("lw10b", 1'b0, 32'h10, 3'b010, 32'd0, 1, 32'h8000_00F1, 1'b0);
        do_req("f3_011", 1'b0, 32'h10, 3'b011, 32'd0, 1, 32'd0, 1'b1);
        do_req("lw1000", 1'b0, 32'h1000, 3'b010, 32'd0, 1, 32'd0, 1'b1);
        do_req("sw_ffc", 1'b1, 32'hFFC, 3'b010, 32'h55AA_0011, 1, 32'd0, 1'b0);
        do_req("lw_ffc", 1'b0, 32'hFFC, 3'b010, 32'd0, 1, 32'h55AA_0011, 1'b0);

        // LATENCY=3 with backpressure; a second request is held on req_valid throughout
        sel = 3;
        do_req("l3_sw10", 1'b1, 32'h10, 3'b010, 32'hCAFE_F00D, 3, 32'd0, 1'b0);
        do_req("l3_sw14", 1'b1, 32'h14, 3'b010, 32'h0BAD_C0DE, 3, 32'd0, 1'b0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
        tick();
        req_addr = 32'h14;
        check("bp_busy", 32'(r_ready), 32'd0);
        k = 0;
        while (!r_valid && k < 20) begin tick(); k++; end
        check("bp_lat", 32'(k), 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(r_valid), 32'd1);
            check("bp_hold_rdata", r_rdata, 32'hCAFE_F00D);
            check("bp_hold_ready", 32'(r_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("bp_hs_valid", 32'(r_valid), 32'd0);
        check("bp_hs_idle", 32'(r_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("bp_next_accepted", 32'(r_ready), 32'd0);
        k = 0;
        while (!r_valid && k < 20) begin tick(); k++; end
        check("bp_next_lat", 32'(k), 32'd2);
        check("bp_next_rdata", r_rdata, 32'h0BAD_C0DE);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("bp_next_done", 32'(r_valid), 32'd0);

        // LATENCY=4, reset while the store waits
        sel = 4;
        do_req("l4_sw40", 1'b1, 32'h40, 3'b010, 32'h1122_3344, 4, 32'd0, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_funct3 = 3'b010;
        req_wdata = 32'hDEAD_BEEF;
        tick();
        req_valid = 1'b0;
        check("rw_accepted", 32'(r_ready), 32'd0);
        tick();
        rst4 = 1'b1;
        #1;
        check("rw_rst_valid", 32'(r_valid), 32'd0);
        check("rw_rst_ready", 32'(r_ready), 32'd1);
        tick();
        rst4 = 1'b0;
        #1;
        check("rw_post_valid", 32'(r_valid), 32'd0);
        check("rw_post_ready", 32'(r_ready), 32'd1);
        tick(); tick(); tick();
        check("rw_no_resp", 32'(r_valid), 32'd0);
        do_req("l4_lw40", 1'b0, 32'h40, 3'b010, 32'd0, 4, 32'h1122_3344, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
